// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_stage.sv
// RV32 MEM stage: word loads/stores over a req/ready bus, upstream stall, MEM/WB register.
// Optional macro MEM_MISALIGN_CHECK_EN rejects misaligned accesses with a misalign_err pulse.
module mem_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [4:0]         ctrl_mem,
  input  logic [4:0]         rd_mem,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        write_data1,
  input  logic [31:0]        pc4_mem,
  mem_stage_if.master        dmem,
  output logic               stall_out,
  output logic               bus_err,
  output logic               reg_write_wb,
  output logic [4:0]         rd_wb,
  output logic [31:0]        wb_data
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic               misalign_err
`endif
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  localparam logic [7:0] LastWait = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc4_q, pc4_d;
  logic        reg_write_wb_q, reg_write_wb_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        bus_err_q, bus_err_d;
  logic        misalign_q, misalign_d;
  logic        stall_raw;
  logic        mem_op;
  logic        misaligned;

  assign mem_op = ctrl_mem[0] | ctrl_mem[1];

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned   = (alu_result[1:0] != 2'b00);
  assign misalign_err = misalign_q;
`else
  assign misaligned   = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rw_d           = rw_q;
    wb_sel_d       = wb_sel_q;
    rd_d           = rd_q;
    pc4_d          = pc4_q;
    reg_write_wb_d = reg_write_wb_q;
    rd_wb_d        = rd_wb_q;
    wb_data_d      = wb_data_q;
    bus_err_d      = 1'b0;
    misalign_d     = 1'b0;
    stall_raw      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_op && !misaligned) begin
          stall_raw      = 1'b1;
          we_d           = ctrl_mem[0];
          addr_d         = {alu_result[31:2], 2'b00};
          wdata_d        = write_data1;
          rw_d           = ctrl_mem[2];
          wb_sel_d       = ctrl_mem[4:3];
          rd_d           = rd_mem;
          pc4_d          = pc4_mem;
          reg_write_wb_d = 1'b0;
          cnt_d          = 8'd0;
          state_d        = StAccess;
        end else if (mem_op) begin
          // Rejected misaligned access: bubble to WB, no bus traffic.
          reg_write_wb_d = 1'b0;
          misalign_d     = 1'b1;
        end else begin
          reg_write_wb_d = ctrl_mem[2];
          rd_wb_d        = rd_mem;
          wb_data_d      = (ctrl_mem[4:3] == 2'b10) ? pc4_mem : alu_result;
        end
      end
      StAccess: begin
        if (dmem.dmem_ready) begin
          reg_write_wb_d = rw_q & ~we_q;
          rd_wb_d        = rd_q;
          unique case (wb_sel_q)
            2'b01:   wb_data_d = dmem.dmem_rdata;
            2'b10:   wb_data_d = pc4_q;
            default: wb_data_d = addr_q;
          endcase
          state_d = StIdle;
        end else if (cnt_q == LastWait) begin
          // Abort: stall is released so the upstream moves on with this edge.
          bus_err_d      = 1'b1;
          reg_write_wb_d = 1'b0;
          state_d        = StIdle;
        end else begin
          stall_raw      = 1'b1;
          reg_write_wb_d = 1'b0;
          cnt_d          = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      cnt_q          <= 8'd0;
      we_q           <= 1'b0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      rw_q           <= 1'b0;
      wb_sel_q       <= 2'b00;
      rd_q           <= 5'd0;
      pc4_q          <= 32'd0;
      reg_write_wb_q <= 1'b0;
      rd_wb_q        <= 5'd0;
      wb_data_q      <= 32'd0;
      bus_err_q      <= 1'b0;
      misalign_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rw_q           <= rw_d;
      wb_sel_q       <= wb_sel_d;
      rd_q           <= rd_d;
      pc4_q          <= pc4_d;
      reg_write_wb_q <= reg_write_wb_d;
      rd_wb_q        <= rd_wb_d;
      wb_data_q      <= wb_data_d;
      bus_err_q      <= bus_err_d;
      misalign_q     <= misalign_d;
    end
  end

  // Stall is gated by reset so it drops immediately even with a memory op still presented.
  assign stall_out       = stall_raw & reset_n;
  assign dmem.dmem_req   = (state_q == StAccess);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign bus_err         = bus_err_q;
  assign reg_write_wb    = reg_write_wb_q;
  assign rd_wb           = rd_wb_q;
  assign wb_data         = wb_data_q;

`ifndef MEM_MISALIGN_CHECK_EN
  logic unused_misalign;
  assign unused_misalign = misalign_q ^ misaligned;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for non-memory ops plus hand-written bus sequences.
module tb_mem_stage;

  logic        clk;
  logic        reset_n;
  logic [4:0]  ctrl_mem;
  logic [4:0]  rd_mem;
  logic [31:0] alu_result;
  logic [31:0] write_data1;
  logic [31:0] pc4_mem;
  logic        stall_out;
  logic        bus_err;
  logic        reg_write_wb;
  logic [4:0]  rd_wb;
  logic [31:0] wb_data;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  mem_stage_if bus ();

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ctrl_mem     (ctrl_mem),
    .rd_mem       (rd_mem),
    .alu_result   (alu_result),
    .write_data1  (write_data1),
    .pc4_mem      (pc4_mem),
    .dmem         (bus),
    .stall_out    (stall_out),
    .bus_err      (bus_err),
    .reg_write_wb (reg_write_wb),
    .rd_wb        (rd_wb),
    .wb_data      (wb_data)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic        exp_rw;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int stalls;
    int accesses;

    vecs[0] = '{5'b00100, 5'd5, 32'h0000_1234, 32'h0000_0008, 1'b1, 5'd5, 32'h0000_1234};
    vecs[1] = '{5'b10100, 5'd1, 32'h0000_0010, 32'h0000_0048, 1'b1, 5'd1, 32'h0000_0048};
    vecs[2] = '{5'b11100, 5'd2, 32'h0000_ABCD, 32'h0000_0099, 1'b1, 5'd2, 32'h0000_ABCD};
    vecs[3] = '{5'b01100, 5'd3, 32'h0000_0077, 32'h0000_0004, 1'b1, 5'd3, 32'h0000_0077};
    vecs[4] = '{5'b00000, 5'd4, 32'hFFFF_0000, 32'h0000_0001, 1'b0, 5'd4, 32'hFFFF_0000};
    vecs[5] = '{5'b00100, 5'd6, 32'h0000_5A5A, 32'h0000_0000, 1'b1, 5'd6, 32'h0000_5A5A};

    reset_n        = 1'b0;
    ctrl_mem       = 5'd0;
    rd_mem         = 5'd0;
    alu_result     = 32'd0;
    write_data1    = 32'd0;
    pc4_mem        = 32'd0;
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 32'd0;

    #12;
    chk("reset req", 32'(bus.dmem_req), 32'd0);
    chk("reset stall", 32'(stall_out), 32'd0);
    chk("reset rw_wb", 32'(reg_write_wb), 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Non-memory ops; ready held high to show it is ignored without a request.
    bus.dmem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ctrl_mem   = vecs[i].ctrl;
      rd_mem     = vecs[i].rd;
      alu_result = vecs[i].alu;
      pc4_mem    = vecs[i].pc4;
      #1;
      chk($sformatf("vec%0d stall", i), 32'(stall_out), 32'd0);
      chk($sformatf("vec%0d req", i), 32'(bus.dmem_req), 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d rw_wb", i), 32'(reg_write_wb), 32'(vecs[i].exp_rw));
      chk($sformatf("vec%0d rd_wb", i), 32'(rd_wb), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d wb_data", i), wb_data, vecs[i].exp_data);
    end

    // Zero-wait load.
    ctrl_mem       = 5'b01110;
    rd_mem         = 5'd7;
    alu_result     = 32'h0000_0100;
    bus.dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld stall idle", 32'(stall_out), 32'd1);
    @(negedge clk);
    chk("ld req", 32'(bus.dmem_req), 32'd1);
    chk("ld we", 32'(bus.dmem_we), 32'd0);
    chk("ld addr", bus.dmem_addr, 32'h0000_0100);
    chk("ld stall access", 32'(stall_out), 32'd0);
    chk("ld bubble", 32'(reg_write_wb), 32'd0);
    @(negedge clk);
    chk("ld done req", 32'(bus.dmem_req), 32'd0);
    chk("ld rw_wb", 32'(reg_write_wb), 32'd1);
    chk("ld rd_wb", 32'(rd_wb), 32'd7);
    chk("ld wb_data", wb_data, 32'hDEAD_BEEF);
    ctrl_mem = 5'b00000;

    // Store with three wait cycles.
    bus.dmem_ready = 1'b0;
    ctrl_mem       = 5'b00001;
    rd_mem         = 5'd3;
    alu_result     = 32'h0000_0206;
    write_data1    = 32'hCAFE_F00D;
    stalls         = 0;
    #1;
    if (stall_out) stalls++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.dmem_ready = (k == 3);
      write_data1    = 32'h1111_1111;
      #1;
      if (stall_out) stalls++;
      chk($sformatf("st req c%0d", k), 32'(bus.dmem_req), 32'd1);
      chk($sformatf("st we c%0d", k), 32'(bus.dmem_we), 32'd1);
      chk($sformatf("st addr c%0d", k), bus.dmem_addr, 32'h0000_0204);
      chk($sformatf("st wdata c%0d", k), bus.dmem_wdata, 32'hCAFE_F00D);
    end
    chk("st stall count", 32'(stalls), 32'd4);
    @(negedge clk);
    chk("st done req", 32'(bus.dmem_req), 32'd0);
    chk("st rw_wb", 32'(reg_write_wb), 32'd0);
    ctrl_mem       = 5'b00000;
    bus.dmem_ready = 1'b0;

    // Restore reg_write_wb=1 so the timeout bubble is observable.
    ctrl_mem   = 5'b00100;
    rd_mem     = 5'd8;
    alu_result = 32'h0000_0088;
    @(negedge clk);
    chk("pre-to rw_wb", 32'(reg_write_wb), 32'd1);

    // Timeout (MAX_WAIT=4) with ready held low.
    ctrl_mem   = 5'b01110;
    rd_mem     = 5'd10;
    alu_result = 32'h0000_0040;
    accesses   = 0;
    #1;
    chk("to stall idle", 32'(stall_out), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (bus.dmem_req) begin
        accesses++;
        chk($sformatf("to stall c%0d", k), 32'(stall_out), 32'(k != 3));
        chk($sformatf("to bus_err c%0d", k), 32'(bus_err), 32'd0);
      end else begin
        break;
      end
    end
    chk("to access count", 32'(accesses), 32'd4);
    chk("to bus_err pulse", 32'(bus_err), 32'd1);
    chk("to bubble", 32'(reg_write_wb), 32'd0);
    ctrl_mem   = 5'b00100;
    rd_mem     = 5'd9;
    alu_result = 32'h0000_0055;
    #1;
    chk("to next stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    chk("to bus_err clear", 32'(bus_err), 32'd0);
    chk("to next rw_wb", 32'(reg_write_wb), 32'd1);
    chk("to next rd_wb", 32'(rd_wb), 32'd9);
    chk("to next wb_data", wb_data, 32'h0000_0055);

    // Reset in the middle of an access.
    ctrl_mem   = 5'b01110;
    rd_mem     = 5'd11;
    alu_result = 32'h0000_0300;
    @(negedge clk);
    chk("rst pre req", 32'(bus.dmem_req), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst req drop", 32'(bus.dmem_req), 32'd0);
    chk("rst stall drop", 32'(stall_out), 32'd0);
    ctrl_mem = 5'b00000;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst addr", bus.dmem_addr, 32'd0);
    chk("rst we", 32'(bus.dmem_we), 32'd0);
    chk("rst rw_wb", 32'(reg_write_wb), 32'd0);
    chk("rst rd_wb", 32'(rd_wb), 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst stall", 32'(stall_out), 32'd0);

    // JAL-style op gives the pipeline a reg_write=1 entry before the next bubble.
    @(negedge clk);
    ctrl_mem   = 5'b10100;
    rd_mem     = 5'd1;
    alu_result = 32'h0000_0999;
    pc4_mem    = 32'h0000_0048;
    @(negedge clk);
    chk("jal wb_data", wb_data, 32'h0000_0048);
    chk("jal rw_wb", 32'(reg_write_wb), 32'd1);

    // Misaligned load at 0x101.
    ctrl_mem       = 5'b01110;
    rd_mem         = 5'd12;
    alu_result     = 32'h0000_0101;
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 32'h1234_5678;
`ifdef MEM_MISALIGN_CHECK_EN
    #1;
    chk("mis stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    chk("mis req", 32'(bus.dmem_req), 32'd0);
    chk("mis err", 32'(misalign_err), 32'd1);
    chk("mis rw_wb", 32'(reg_write_wb), 32'd0);
    ctrl_mem = 5'b00000;
    @(negedge clk);
    chk("mis err clear", 32'(misalign_err), 32'd0);
`else
    #1;
    chk("unal stall", 32'(stall_out), 32'd1);
    @(negedge clk);
    chk("unal req", 32'(bus.dmem_req), 32'd1);
    chk("unal addr", bus.dmem_addr, 32'h0000_0100);
    @(negedge clk);
    chk("unal wb_data", wb_data, 32'h1234_5678);
    chk("unal rd_wb", 32'(rd_wb), 32'd12);
    ctrl_mem = 5'b00000;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RV32 pipeline; consumes the EX/MEM register outputs (control, rd, ALU result, store data, PC+4).
- Performs word loads/stores over a req/ready data-memory bus and stalls upstream while an access is outstanding.
- Registers the selected writeback value, rd and reg_write into the MEM/WB register for the WB stage.

Parameters:
- MAX_WAIT, 15, maximum ACCESS cycles without dmem_ready before the access is aborted; legal range 1..255.

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- ctrl_mem  in  5  [0] mem_write, [1] mem_read, [2] reg_write, [4:3] wb_sel (00 ALU, 01 load data, 10 PC+4, 11 ALU)
- rd_mem  in  5  destination register index
- alu_result  in  32  ALU result / memory byte address
- write_data1  in  32  store data
- pc4_mem  in  32  PC+4 of the instruction
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  word address, bits [1:0] always 0
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid when dmem_ready=1
- dmem_ready  in  1  access completes on a clk edge where dmem_req=1 and dmem_ready=1
- stall_out  out  1  holds the PC, IF/ID, ID/EX and EX/MEM registers
- bus_err  out  1  one-cycle pulse: access aborted by timeout
- reg_write_wb  out  1  MEM/WB reg_write
- rd_wb  out  5  MEM/WB rd
- wb_data  out  32  MEM/WB writeback value

Behaviour:
- Reset (async, immediate): state IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0; stall_out=0, bus_err=0; reg_write_wb=0, rd_wb=0, wb_data=0; wait counter=0. Reset during ACCESS drops dmem_req immediately and discards the access.
- A memory op is ctrl_mem[0] or ctrl_mem[1]. If both are set, the op is a store (mem_write has priority).
- IDLE, no memory op:
  - stall_out=0.
  - On the edge, MEM/WB loads reg_write_wb=ctrl_mem[2], rd_wb=rd_mem, wb_data=pc4_mem if wb_sel=10, else alu_result.
  - Latency: 1 cycle.
- IDLE, memory op:
  - stall_out=1 combinationally.
  - On the edge: latch address {alu_result[31:2],2'b00}, write_data1, we, ctrl_mem[2], wb_sel, rd_mem, pc4_mem; MEM/WB loads a bubble (reg_write_wb=0); counter cleared; go to ACCESS.
- ACCESS:
  - dmem_req=1; dmem_we/addr/wdata come from the latched registers and stay stable for the whole access.
  - stall_out = ~dmem_ready.
  - Edge with dmem_ready=1: MEM/WB loads latched reg_write (forced 0 for stores), latched rd, and wb_data = dmem_rdata if wb_sel=01, PC+4 if 10, else address; go to IDLE. The upstream register advances on the same edge.
  - Edge with dmem_ready=0: counter+1. When counter = MAX_WAIT-1, the next edge without ready aborts: bus_err=1 for 1 cycle, MEM/WB loads a bubble, go to IDLE, stall released (stall_out=0 in that final cycle).
- Minimum memory-op latency: 2 cycles in MEM (1 stall cycle) with zero-wait memory.
- Back-to-back memory ops each pass through IDLE→ACCESS; there is no overlap.
- dmem_ready while dmem_req=0 is ignored.
- Out of reset, outputs are driven from registers except stall_out and dmem_req, which are decoded from state and inputs.

Optional Feature:
- Macro MEM_MISALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_err (1 bit, reset 0).
  - An IDLE memory op with alu_result[1:0]≠00 does not enter ACCESS and issues no request; stall_out=0.
  - MEM/WB loads a bubble; misalign_err pulses 1 cycle.
- Not defined: no port; address bits [1:0] are silently dropped and the access proceeds aligned.

Test Plan:
- ALU op: ctrl_mem=5'b00100, rd=5, alu_result=0x1234 → next edge reg_write_wb=1, rd_wb=5, wb_data=0x1234, stall_out never 1.
- Load, zero-wait: ctrl=5'b01110, addr=0x100, ready tied 1, rdata=0xDEADBEEF → stall_out high 1 cycle, dmem_addr=0x100, we=0, then wb_data=0xDEADBEEF, rd_wb correct.
- Store, 3 wait cycles: ctrl=5'b00001, addr=0x206, data=0xCAFEF00D → dmem_addr=0x204 and wdata stable for 4 ACCESS cycles, we=1, stall 4 cycles total, reg_write_wb=0.
- Timeout with MAX_WAIT=4, ready held 0 → exactly 4 ACCESS cycles, bus_err pulses once, bubble to WB, stall_out drops, next instruction proceeds.
- Reset asserted mid-ACCESS → dmem_req and stall_out fall without a clock; after release, state IDLE, all outputs 0.
- JAL-style op: wb_sel=10, pc4=0x48, reg_write=1 → wb_data=0x48. With MEM_MISALIGN_CHECK_EN: load at addr 0x101 → no dmem_req, misalign_err pulse, reg_write_wb=0.
